bus_sequencer_arbiter: RTL and testbench



---
 rtl/bus_sequencer_pkg.sv | 41 ++++
 rtl/bus_sequencer_arbiter_rr.sv | 47 ++++
 rtl/bus_sequencer_arbiter.sv | 170 +++++++++++++++++
 tb/tb_bus_sequencer_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sequencer_pkg.sv
// Shared types and helpers for the bus sequencer arbiter.
//   arb_state_t : arbiter FSM states
//   rr_pick()   : round-robin search over up to 16 requesters
package bus_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    FINISH
  } arb_state_t;

  localparam int unsigned RR_MAX_REQ = 16;
  localparam int unsigned RR_IDX_W   = 4;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0], searching upward from ptr with wrap-around.
  // ptr must be < n; requests at or above n are ignored.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                       input logic [RR_IDX_W-1:0]   ptr,
                                       input int unsigned           n);
    rr_pick_t    r;
    int unsigned c;
    r = '0;
    for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
      c = {28'd0, ptr} + i;
      if (c >= n) c = c - n;
      if ((i < n) && !r.found && req[c[RR_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = c[RR_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_sequencer_arbiter_rr.sv
// Round-robin picker plus its priority-pointer register.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   req_i          : request levels
//   advance_i      : move the pointer past owner_i (one cycle, at completion)
//   owner_i        : index of the requester that just completed
//   pick_idx_o     : winning index for the current req_i
//   pick_found_o   : at least one request present
module rr_arbiter_core
  import bus_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic                advance_i,
  input  logic [RR_IDX_W-1:0] owner_i,
  output logic [RR_IDX_W-1:0] pick_idx_o,
  output logic                pick_found_o
);

  logic [RR_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [RR_MAX_REQ-1:0] req_pad;
  rr_pick_t              pick;

  always_comb begin
    req_pad                = '0;
    req_pad[NUM_REQ-1:0]   = req_i;
    pick                   = rr_pick(req_pad, rr_ptr_q, NUM_REQ);
  end

  assign pick_idx_o   = pick.idx;
  assign pick_found_o = pick.found;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance_i) begin
      rr_ptr_d = (owner_i == RR_IDX_W'(NUM_REQ - 1)) ? '0 : owner_i + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/bus_sequencer_arbiter.sv
// Shares one bus sequencer between NUM_REQ requesters, round-robin.
// Latches the winner's start address, pulses seq_start_o, waits for the
// sequence to finish and routes read bytes back to the owner.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   req_i, req_addr_i  : per-requester request level / start address slice
//   grant_o, done_o    : one-hot owner, one-cycle completion pulse
//   rd_valid_o/rd_data_o : registered read byte routed to the owner
//   busy_o             : FSM not IDLE
//   seq_*              : sequencer start/address/ready/data interface
// Optional: define BUS_SEQ_ARB_TIMEOUT_EN to add TIMEOUT_CYCLES and
// timeout_o, a WAIT_DONE watchdog that forces completion.
module bus_sequencer_arbiter
  import bus_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned BUSY_WAIT_MAX = 4
`ifdef BUS_SEQ_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [NUM_REQ-1:0]            rd_valid_o,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic                          busy_o,
  output logic                          seq_start_o,
  output logic [ADDR_WIDTH-1:0]         seq_start_addr_o,
  input  logic                          seq_ready_i,
  input  logic                          seq_data_valid_i,
  input  logic [DATA_WIDTH-1:0]         seq_data_i
`ifdef BUS_SEQ_ARB_TIMEOUT_EN
  ,
  output logic                          timeout_o
`endif
);

  localparam int unsigned BW = $clog2(BUSY_WAIT_MAX) + 1;

  arb_state_t            state_q, state_d;
  logic [RR_IDX_W-1:0]   owner_q, owner_d, pick_idx;
  logic                  pick_found;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BW-1:0]         busy_cnt_q, busy_cnt_d;
  logic                  start_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [NUM_REQ-1:0]    rd_valid_q, owner_oh;
`ifdef BUS_SEQ_ARB_TIMEOUT_EN
  logic [15:0]           wd_cnt_q, wd_cnt_d;
  logic                  to_q, to_d;
`endif

  rr_arbiter_core #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .advance_i    (state_q == FINISH),
    .owner_i      (owner_q),
    .pick_idx_o   (pick_idx),
    .pick_found_o (pick_found)
  );

  always_comb begin
    owner_oh = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      owner_oh[k] = ({28'd0, owner_q} == k);
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    busy_cnt_d = busy_cnt_q;
`ifdef BUS_SEQ_ARB_TIMEOUT_EN
    wd_cnt_d   = '0;
    to_d       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (seq_ready_i && pick_found) begin
          owner_d = pick_idx;
          addr_d  = req_addr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          state_d = START;
        end
      end
      START: begin
        busy_cnt_d = '0;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // Ready never dropping within the window means the sequence
        // already completed.
        if (!seq_ready_i) begin
          state_d = WAIT_DONE;
        end else if (busy_cnt_q == BW'(BUSY_WAIT_MAX - 1)) begin
          state_d = FINISH;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
`ifdef BUS_SEQ_ARB_TIMEOUT_EN
        if (seq_ready_i) begin
          state_d = FINISH;
        end else if (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d = FINISH;
          to_d    = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`else
        if (seq_ready_i) state_d = FINISH;
`endif
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      addr_q     <= '0;
      busy_cnt_q <= '0;
      start_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
`ifdef BUS_SEQ_ARB_TIMEOUT_EN
      wd_cnt_q   <= '0;
      to_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      busy_cnt_q <= busy_cnt_d;
      // Registered so the start pulse lands one cycle after the grant.
      start_q    <= (state_q == START);
      if (seq_data_valid_i && busy_o) rd_data_q <= seq_data_i;
      rd_valid_q <= (seq_data_valid_i && busy_o) ? owner_oh : '0;
`ifdef BUS_SEQ_ARB_TIMEOUT_EN
      wd_cnt_q   <= wd_cnt_d;
      to_q       <= to_d;
`endif
    end
  end

  assign busy_o           = (state_q != IDLE);
  assign grant_o          = busy_o ? owner_oh : '0;
  assign done_o           = (state_q == FINISH) ? owner_oh : '0;
  assign seq_start_o      = start_q;
  assign seq_start_addr_o = addr_q;
  assign rd_data_o        = rd_data_q;
  assign rd_valid_o       = rd_valid_q;
`ifdef BUS_SEQ_ARB_TIMEOUT_EN
  assign timeout_o        = to_q;
`endif

endmodule

// File: tb/tb_bus_sequencer_arbiter.sv
// Directed bench for bus_sequencer_arbiter: a cycle table for a data-routing
// transaction plus hand-written multi-cycle sequences.
module tb_bus_sequencer_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [127:0] req_addr_i;
  logic [31:0] addr [4];
  logic [3:0]  grant_o, done_o, rd_valid_o;
  logic [7:0]  rd_data_o;
  logic        busy_o, seq_start_o;
  logic [31:0] seq_start_addr_o;
  logic        seq_ready_i, seq_data_valid_i;
  logic [7:0]  seq_data_i;
`ifdef BUS_SEQ_ARB_TIMEOUT_EN
  logic        timeout_o;
`endif

  int total = 0;
  int bad   = 0;
  int n_start = 0;

  always #5 clk = ~clk;

  always_comb req_addr_i = {addr[3], addr[2], addr[1], addr[0]};

  always @(posedge clk) if (seq_start_o) n_start++;

  bus_sequencer_arbiter #(
    .NUM_REQ       (4),
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (8),
    .BUSY_WAIT_MAX (4)
`ifdef BUS_SEQ_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (100)
`endif
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .req_i            (req_i),
    .req_addr_i       (req_addr_i),
    .grant_o          (grant_o),
    .done_o           (done_o),
    .rd_valid_o       (rd_valid_o),
    .rd_data_o        (rd_data_o),
    .busy_o           (busy_o),
    .seq_start_o      (seq_start_o),
    .seq_start_addr_o (seq_start_addr_o),
    .seq_ready_i      (seq_ready_i),
    .seq_data_valid_i (seq_data_valid_i),
    .seq_data_i       (seq_data_i)
`ifdef BUS_SEQ_ARB_TIMEOUT_EN
    ,
    .timeout_o        (timeout_o)
`endif
  );

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic        vld;
    logic [7:0]  dat;
    logic [31:0] a2;
    logic [3:0]  e_gnt;
    logic [3:0]  e_done;
    logic        e_start;
    logic        e_busy;
    logic [3:0]  e_rdv;
    logic [7:0]  e_rdd;
    logic [31:0] e_sa;
  } vec_t;

  vec_t vt [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Grants req, emulates the sequencer (ready drops drop cycles after the
  // start pulse and stays low blen cycles), waits for done, checks the gap.
  task automatic run_txn(input logic [3:0] req, input int drop, input int blen,
                         input logic [31:0] eaddr, output logic [3:0] g,
                         output int nst);
    int s0;
    req_i = req;
    seq_ready_i = 1'b1;
    g = '0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (grant_o != 0) begin
        g = grant_o;
        break;
      end
    end
    chk("txn_addr", seq_start_addr_o, eaddr);
    s0 = n_start;
    step();
    chk("txn_start", {31'd0, seq_start_o}, 32'd1);
    nst = 0;
    for (int i = 0; i < drop; i++) begin
      step();
      nst++;
    end
    if (blen > 0) begin
      seq_ready_i = 1'b0;
      for (int i = 0; i < blen; i++) begin
        step();
        nst++;
      end
      seq_ready_i = 1'b1;
    end
    for (int n = 0; n < 40; n++) begin
      step();
      nst++;
      if (done_o != 0) break;
    end
    chk("txn_done_owner", {28'd0, done_o}, {28'd0, g});
    chk("txn_one_start", n_start - s0, 32'd1);
    step();
    chk("txn_gap_busy", {31'd0, busy_o}, 32'd0);
    chk("txn_gap_grant", {28'd0, grant_o}, 32'd0);
  endtask

  logic [3:0] g;
  int         nst;
  logic [3:0] rr_exp [5];

  initial begin
    //        req    rdy  vld  dat    a2            gnt    done   st  bsy rdv    rdd    sa
    vt[0]  = '{4'h4, 1'b1, 1'b0, 8'h00, 32'h2222_0002, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0};
    vt[1]  = '{4'h4, 1'b1, 1'b0, 8'h00, 32'h2222_0002, 4'h4, 4'h0, 1'b0, 1'b1, 4'h0, 8'h00, 32'h2222_0002};
    vt[2]  = '{4'h4, 1'b0, 1'b0, 8'h00, 32'h2222_0002, 4'h4, 4'h0, 1'b1, 1'b1, 4'h0, 8'h00, 32'h2222_0002};
    vt[3]  = '{4'h4, 1'b0, 1'b1, 8'hA5, 32'hDEAD_BEEF, 4'h4, 4'h0, 1'b0, 1'b1, 4'h0, 8'h00, 32'h2222_0002};
    vt[4]  = '{4'h4, 1'b0, 1'b1, 8'h5A, 32'hDEAD_BEEF, 4'h4, 4'h0, 1'b0, 1'b1, 4'h4, 8'hA5, 32'h2222_0002};
    vt[5]  = '{4'h4, 1'b0, 1'b0, 8'h00, 32'hDEAD_BEEF, 4'h4, 4'h0, 1'b0, 1'b1, 4'h4, 8'h5A, 32'h2222_0002};
    vt[6]  = '{4'h4, 1'b0, 1'b1, 8'hFF, 32'hDEAD_BEEF, 4'h4, 4'h0, 1'b0, 1'b1, 4'h0, 8'h5A, 32'h2222_0002};
    vt[7]  = '{4'h0, 1'b1, 1'b0, 8'h00, 32'hDEAD_BEEF, 4'h4, 4'h0, 1'b0, 1'b1, 4'h4, 8'hFF, 32'h2222_0002};
    vt[8]  = '{4'h0, 1'b1, 1'b0, 8'h00, 32'hDEAD_BEEF, 4'h4, 4'h4, 1'b0, 1'b1, 4'h0, 8'hFF, 32'h2222_0002};
    vt[9]  = '{4'h0, 1'b1, 1'b1, 8'h33, 32'hDEAD_BEEF, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 8'hFF, 32'h2222_0002};
    vt[10] = '{4'h0, 1'b1, 1'b0, 8'h00, 32'hDEAD_BEEF, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 8'hFF, 32'h2222_0002};
    vt[11] = '{4'h0, 1'b1, 1'b0, 8'h00, 32'hDEAD_BEEF, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 8'hFF, 32'h2222_0002};

    addr[0] = 32'h0000_0100;
    addr[1] = 32'h0000_0010;
    addr[2] = 32'h2222_0002;
    addr[3] = 32'h3000_0003;
    rst_i = 1'b1;
    req_i = '0;
    seq_ready_i = 1'b1;
    seq_data_valid_i = 1'b0;
    seq_data_i = '0;
    step();
    step();
    rst_i = 1'b0;

    // Data routing to owner 2, mid-transaction req drop and address change.
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("v%0d_grant", i), {28'd0, grant_o}, {28'd0, vt[i].e_gnt});
      chk($sformatf("v%0d_done", i), {28'd0, done_o}, {28'd0, vt[i].e_done});
      chk($sformatf("v%0d_start", i), {31'd0, seq_start_o}, {31'd0, vt[i].e_start});
      chk($sformatf("v%0d_busy", i), {31'd0, busy_o}, {31'd0, vt[i].e_busy});
      chk($sformatf("v%0d_rdvalid", i), {28'd0, rd_valid_o}, {28'd0, vt[i].e_rdv});
      chk($sformatf("v%0d_rddata", i), {24'd0, rd_data_o}, {24'd0, vt[i].e_rdd});
      chk($sformatf("v%0d_saddr", i), seq_start_addr_o, vt[i].e_sa);
      req_i = vt[i].req;
      seq_ready_i = vt[i].rdy;
      seq_data_valid_i = vt[i].vld;
      seq_data_i = vt[i].dat;
      addr[2] = vt[i].a2;
    end
    seq_data_valid_i = 1'b0;

    // Single request, ready low for 20 cycles.
    run_txn(4'h2, 2, 20, 32'h0000_0010, g, nst);
    chk("single_grant", {28'd0, g}, 32'h2);
    chk("single_len", nst, 32'd23);
    req_i = '0;

    // Fast sequence: ready never drops, four WAIT_BUSY cycles.
    run_txn(4'h8, 0, 0, 32'h3000_0003, g, nst);
    chk("fast_grant", {28'd0, g}, 32'h8);
    chk("fast_len", nst, 32'd4);
    req_i = '0;

    // Round robin with all requesting, pointer now at 0.
    rr_exp[0] = 4'h1; rr_exp[1] = 4'h2; rr_exp[2] = 4'h4; rr_exp[3] = 4'h8; rr_exp[4] = 4'h1;
    for (int i = 0; i < 5; i++) begin
      run_txn(4'hF, 2, 3, addr[$clog2(rr_exp[i])], g, nst);
      chk($sformatf("rr%0d_grant", i), {28'd0, g}, {28'd0, rr_exp[i]});
      chk($sformatf("rr%0d_len", i), nst, 32'd6);
    end

    // Single active requester held high is granted once per sequence.
    for (int i = 0; i < 2; i++) begin
      run_txn(4'h1, 0, 0, 32'h0000_0100, g, nst);
      chk($sformatf("repeat%0d_grant", i), {28'd0, g}, 32'h1);
    end
    req_i = '0;

    // Reset in WAIT_DONE; no grant while ready is low afterwards.
    addr[2] = 32'h2222_0002;
    req_i = 4'h4;
    seq_ready_i = 1'b1;
    step();
    chk("rst_pre_grant", {28'd0, grant_o}, 32'h4);
    step();
    seq_ready_i = 1'b0;
    step();
    step();
    chk("rst_pre_busy", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rst_grant", {28'd0, grant_o}, 32'd0);
    chk("rst_done", {28'd0, done_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_start", {31'd0, seq_start_o}, 32'd0);
    chk("rst_rdvalid", {28'd0, rd_valid_o}, 32'd0);
    chk("rst_rddata", {24'd0, rd_data_o}, 32'd0);
    chk("rst_saddr", seq_start_addr_o, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_hold%0d_grant", i), {28'd0, grant_o}, 32'd0);
    end
    seq_ready_i = 1'b1;
    step();
    chk("rst_regrant", {28'd0, grant_o}, 32'h4);
    chk("rst_regrant_addr", seq_start_addr_o, 32'h2222_0002);
    req_i = '0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (done_o != 0) break;
    end
    chk("rst_after_done", {28'd0, done_o}, 32'h4);
    step();

`ifdef BUS_SEQ_ARB_TIMEOUT_EN
    // Watchdog: ready stuck low after the start pulse.
    req_i = 4'h1;
    seq_ready_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      if (grant_o != 0) break;
    end
    req_i = '0;
    step();
    chk("to_start", {31'd0, seq_start_o}, 32'd1);
    step();
    step();
    seq_ready_i = 1'b0;
    nst = 2;
    for (int n = 0; n < 200; n++) begin
      step();
      nst++;
      if (done_o != 0) break;
    end
    chk("to_len", nst, 32'd103);
    chk("to_done", {28'd0, done_o}, 32'h1);
    chk("to_pulse", {31'd0, timeout_o}, 32'd1);
    req_i = 4'h1;
    step();
    chk("to_pulse_end", {31'd0, timeout_o}, 32'd0);
    step();
    chk("to_no_grant", {28'd0, grant_o}, 32'd0);
    seq_ready_i = 1'b1;
    step();
    chk("to_regrant", {28'd0, grant_o}, 32'h1);
    req_i = '0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (done_o != 0) break;
    end
    chk("to_final_done", {28'd0, done_o}, 32'h1);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
